// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic tile datapath.
// Holds the sequencer state enum and array/buffer geometry defaults.
package systolic_pkg;

  localparam int SYS_COLS   = 4;
  localparam int SYS_ROWS   = 4;
  localparam int SYS_DEPTH  = 64;
  localparam int SYS_PTR_W  = 6;
  localparam int DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/skew_addr_gen.sv
// Per-column diagonal skew: column c streams words 0..K-1 at t=c..c+K-1.
// In: active, t, k. Out: col_en[COLS], addr[COLS*PTR_W] (0 when disabled).
module skew_addr_gen #(
  parameter int COLS  = 4,
  parameter int PTR_W = 6
) (
  input  logic                    active,
  input  logic [PTR_W:0]          t,
  input  logic [PTR_W:0]          k,
  output logic [COLS-1:0]         col_en,
  output logic [COLS*PTR_W-1:0]   addr
);

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam logic [PTR_W+1:0] C = (PTR_W + 2)'(c);
    logic [PTR_W+1:0] tw;
    logic [PTR_W+1:0] kw;
    logic             en;

    // One extra bit so c+K never wraps at K=DEPTH.
    assign tw = {1'b0, t};
    assign kw = {1'b0, k};
    assign en = active && (tw >= C) && (tw < C + kw);

    assign col_en[c] = en;
    assign addr[c*PTR_W +: PTR_W] =
      en ? (t[PTR_W-1:0] - C[PTR_W-1:0]) : '0;
  end

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Command-driven tile sequencer: load K beats, skewed stream, drain, done.
// In: clk, rst_n, start, k_len, abort, ld_data_valid. Out: ld_*, stream_*, acc_clear, busy, done.
module systolic_tile_sequencer
  import systolic_pkg::*;
#(
  parameter int COLS         = SYS_COLS,
  parameter int ROWS         = SYS_ROWS,
  parameter int DEPTH        = SYS_DEPTH,
  parameter int PTR_W        = SYS_PTR_W,
  parameter int DRAIN_CYCLES = ROWS + COLS - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [PTR_W:0]        k_len,
  input  logic                  abort,
  input  logic                  ld_data_valid,
  output logic                  ld_we,
  output logic [PTR_W-1:0]      ld_addr,
  output logic [COLS-1:0]       stream_col_en,
  output logic [COLS*PTR_W-1:0] stream_addr,
  output logic                  acc_clear,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = PTR_W + 1;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t LAST_DR = cnt_t'(DRAIN_CYCLES - 1);

  seq_state_t state, state_nx;
  cnt_t       k_q, k_nx;
  cnt_t       cnt_q, cnt_nx;
  logic [CW:0] t_end;
  logic        t_last;
  logic        streaming;

  // Stream runs t = 0 .. K+COLS-2.
  assign t_end  = {1'b0, k_q} + (CW + 1)'(COLS - 1);
  assign t_last = ({1'b0, cnt_q} + 1'b1) == t_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k_q   <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      k_q   <= k_nx;
      cnt_q <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    k_nx     = k_q;
    cnt_nx   = cnt_q;
    if (abort) begin
      state_nx = IDLE;
      k_nx     = '0;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            k_nx     = (k_len > DEPTH_C) ? DEPTH_C : k_len;
            cnt_nx   = '0;
            state_nx = (k_len == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (ld_data_valid) begin
            if ((cnt_q + 1'b1) == k_q) begin
              cnt_nx   = '0;
              state_nx = STREAM;
            end else begin
              cnt_nx = cnt_q + 1'b1;
            end
          end
        end
        STREAM: begin
          if (t_last) begin
            cnt_nx   = '0;
            state_nx = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
          end else begin
            cnt_nx = cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (cnt_q == LAST_DR) begin
            cnt_nx   = '0;
            state_nx = DONE;
          end else begin
            cnt_nx = cnt_q + 1'b1;
          end
        end
        DONE: begin
          k_nx     = '0;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    ld_we     = 1'b0;
    ld_addr   = '0;
    acc_clear = 1'b0;
    streaming = 1'b0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    unique case (state)
      LOAD: begin
        ld_we   = ld_data_valid;
        ld_addr = cnt_q[PTR_W-1:0];
      end
      STREAM: begin
        streaming = 1'b1;
        acc_clear = (cnt_q == '0);
      end
      default: ;
    endcase
  end

  skew_addr_gen #(
    .COLS  (COLS),
    .PTR_W (PTR_W)
  ) u_skew (
    .active (streaming),
    .t      (cnt_q),
    .k      (k_q),
    .col_en (stream_col_en),
    .addr   (stream_addr)
  );

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Randomized bench for systolic_tile_sequencer against a tile-schedule model.
// Model derives each phase window from K, accepted beats and fixed offsets.
module tb_systolic_tile_sequencer;

  localparam int COLS  = 4;
  localparam int ROWS  = 4;
  localparam int DEPTH = 64;
  localparam int PTR_W = 6;
  localparam int DC    = ROWS + COLS - 1;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [PTR_W:0]        k_len;
  logic                  abort;
  logic                  ld_data_valid;
  logic                  ld_we;
  logic [PTR_W-1:0]      ld_addr;
  logic [COLS-1:0]       stream_col_en;
  logic [COLS*PTR_W-1:0] stream_addr;
  logic                  acc_clear;
  logic                  busy;
  logic                  done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  systolic_tile_sequencer #(
    .COLS         (COLS),
    .ROWS         (ROWS),
    .DEPTH        (DEPTH),
    .PTR_W        (PTR_W),
    .DRAIN_CYCLES (DC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .k_len         (k_len),
    .abort         (abort),
    .ld_data_valid (ld_data_valid),
    .ld_we         (ld_we),
    .ld_addr       (ld_addr),
    .stream_col_en (stream_col_en),
    .stream_addr   (stream_addr),
    .acc_clear     (acc_clear),
    .busy          (busy),
    .done          (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic chk_all(input string ph, input bit b, input bit d,
                         input bit we, input int a,
                         input logic [COLS-1:0] en, input bit clr,
                         input logic [COLS*PTR_W-1:0] sa);
    chk({ph, ".busy"},  32'(busy),          32'(b));
    chk({ph, ".done"},  32'(done),          32'(d));
    chk({ph, ".ld_we"}, 32'(ld_we),         32'(we));
    chk({ph, ".ld_ad"}, 32'(ld_addr),       32'(a));
    chk({ph, ".col"},   32'(stream_col_en), 32'(en));
    chk({ph, ".clr"},   32'(acc_clear),     32'(clr));
    chk({ph, ".s_ad"},  32'(stream_addr),   32'(sa));
  endtask

  // Drive one tile and check every cycle against the phase schedule:
  // load until K beats accepted, stream K+COLS-1 cycles, drain DC, done.
  task automatic run_tile(input int k, input int stall_pct,
                          input logic [31:0] stall_mask,
                          input int abort_at, input bit noise);
    int ke, beats, s, dcy, t;
    bit v, ab, fin;
    logic [COLS-1:0] een;
    logic [COLS*PTR_W-1:0] esa;
    ke = (k > DEPTH) ? DEPTH : k;
    @(negedge clk);
    start = 1'b1;
    k_len = (PTR_W + 1)'(k);
    abort = 1'b0;
    @(posedge clk);
    #1;
    beats = 0;
    s     = -1;
    dcy   = (ke == 0) ? 1 : -1;
    fin   = 1'b0;
    for (int n = 1; n < 400 && !fin; n++) begin
      v = (n < 32 && stall_mask[n]) ? 1'b0
          : ($urandom_range(99) >= stall_pct);
      ab = (n == abort_at);
      ld_data_valid = v;
      abort = ab;
      start = noise && ($urandom_range(2) == 0);
      k_len = (PTR_W + 1)'($urandom_range(127));
      @(negedge clk);
      een = '0;
      esa = '0;
      if (ke > 0 && beats < ke) begin
        chk_all("load", 1, 0, v, beats, '0, 0, '0);
      end else if (s > 0 && n >= s && n < s + ke + COLS - 1) begin
        t = n - s;
        for (int c = 0; c < COLS; c++) begin
          if (t >= c && t < c + ke) begin
            een[c] = 1'b1;
            esa[c*PTR_W +: PTR_W] = PTR_W'(t - c);
          end
        end
        chk_all("strm", 1, 0, 0, 0, een, t == 0, esa);
      end else begin
        chk_all(n == dcy ? "done" : "drn", 1, n == dcy, 0, 0, '0, 0, '0);
      end
      if (ke > 0 && beats < ke && v) begin
        beats++;
        if (beats == ke) begin
          s   = n + 1;
          dcy = s + ke + COLS - 1 + DC;
        end
      end
      @(posedge clk);
      #1;
      if (ab || n == dcy) begin
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk_all(ab ? "abrt" : "post", 0, 0, 0, 0, '0, 0, '0);
        fin = 1'b1;
      end
    end
    chk("tile_end", 32'(fin), 32'd1);
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int k, ab;
    rst_n = 1'b0;
    start = 1'b0;
    k_len = '0;
    abort = 1'b0;
    ld_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("rst", 0, 0, 0, 0, '0, 0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_all("idle", 0, 0, 0, 0, '0, 0, '0);
    end

    run_tile(4, 0, 32'h0, -1, 0);
    run_tile(4, 0, 32'h0000_000c, -1, 0);
    run_tile(64, 0, 32'h0, -1, 0);
    run_tile(70, 0, 32'h0, -1, 0);
    run_tile(0, 0, 32'h0, -1, 0);
    run_tile(4, 0, 32'h0, 7, 1);
    run_tile(4, 0, 32'h0, -1, 1);
    run_tile(1, 20, 32'h0, -1, 1);
    run_tile(127, 25, 32'h0, -1, 1);

    // Asynchronous reset in the middle of a load.
    @(negedge clk);
    start = 1'b1;
    k_len = 7'd8;
    ld_data_valid = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("arst", 0, 0, 0, 0, '0, 0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_all("arst_idle", 0, 0, 0, 0, '0, 0, '0);
    end

    for (int i = 0; i < 24; i++) begin
      k  = ($urandom_range(3) == 0) ? $urandom_range(127)
                                    : $urandom_range(12);
      ab = ($urandom_range(3) == 0) ? $urandom_range(1, 30) : -1;
      run_tile(k, 30, 32'h0, ab, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
